// File: rtl/n64_dd_pkg.sv
// Shared register map and CTRL_STATUS layout for the N64 disk-drive controller.
package n64_dd_pkg;

  // Word index (address[4:1]) of each register.
  localparam logic [3:0] REG_DATA        = 4'h0;  // byte offset 0x00
  localparam logic [3:0] REG_CMD         = 4'h4;  // byte offset 0x08
  localparam logic [3:0] REG_BM          = 4'h8;  // byte offset 0x10
  localparam logic [3:0] REG_CTRL_STATUS = 4'hC;  // byte offset 0x18

  // CTRL_STATUS bit positions.
  localparam int unsigned CS_CMD_REQUEST = 0;
  localparam int unsigned CS_HARD_RESET  = 1;

  function automatic logic [15:0] ctrl_status_word(input logic cmd_request,
                                                   input logic hard_reset);
    logic [15:0] word;
    word                 = '0;
    word[CS_CMD_REQUEST] = cmd_request;
    word[CS_HARD_RESET]  = hard_reset;
    return word;
  endfunction

endpackage

// File: rtl/n64_dd_if.sv
// System and N64 bus interfaces used by the disk-drive controller.
interface if_system;
  logic clk;
  logic reset;

  modport sys (input clk, input reset);
endinterface

interface if_n64_bus;
  logic        request;
  logic        write;
  logic [4:1]  address;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;

  modport slave  (input request, input write, input address, input wdata,
                  output rdata, output ack);
  modport master (output request, output write, output address, output wdata,
                  input rdata, input ack);
endinterface

// File: rtl/n64_dd_ctrl.sv
// N64 disk-drive register front end: decodes bus accesses into drive
// commands, data and buffer-manager control, with command back-pressure.
interface if_dd;
  logic        hard_reset;
  logic        cmd_request;
  logic [7:0]  command;
  logic [15:0] data_input;
  logic        bm_request;
  logic [15:0] bm_control;
  logic        cmd_ack;
  logic [15:0] status;
  logic [15:0] data_output;
  logic [15:0] bm_status;

  modport n64 (output hard_reset, output cmd_request, output command,
               output data_input, output bm_request, output bm_control,
               input cmd_ack, input status, input data_output, input bm_status);
  modport dd  (input hard_reset, input cmd_request, input command,
               input data_input, input bm_request, input bm_control,
               output cmd_ack, output status, output data_output, output bm_status);
endinterface

module n64_dd_ctrl (
  if_system.sys    sys,
  if_n64_bus.slave bus,
  input  logic     n64_hard_reset,
  if_dd.n64        dd
);
  import n64_dd_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_CMD_STALL, S_WAIT} e_state;

  e_state      state, state_next;
  logic [3:0]  reg_sel;
  logic        hr_rise;
  logic        locked;
  logic        accept;
  logic        stall;
  logic        release_cmd;
  logic        release_drop;
  logic [7:0]  pend_cmd;
  logic [15:0] rd_value;

  assign reg_sel = bus.address[4:1];
  // Rising edge of the registered hard reset happens on the clock edge where
  // the raw input is high and the register is still low.
  assign hr_rise = n64_hard_reset & ~dd.hard_reset;
  assign locked  = dd.hard_reset | hr_rise;

  // State register.
  always_ff @(posedge sys.clk) begin
    if (sys.reset) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next-state and access strobes.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    stall        = 1'b0;
    release_cmd  = 1'b0;
    release_drop = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.request) begin
          if (bus.write && reg_sel == REG_CMD && dd.cmd_request && !locked) begin
            stall      = 1'b1;
            state_next = S_CMD_STALL;
          end else begin
            accept     = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_CMD_STALL: begin
        if (hr_rise) begin
          release_drop = 1'b1;
          state_next   = S_WAIT;
        end else if (!dd.cmd_request || dd.cmd_ack) begin
          // cmd_ack in this cycle retires the old command and the stalled one
          // takes its place, so cmd_request never drops.
          release_cmd = 1'b1;
          state_next  = S_WAIT;
        end
      end
      S_WAIT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Read-data mux sampled at acceptance.
  always_comb begin
    rd_value = '0;
    case (reg_sel)
      REG_DATA:        rd_value = dd.data_output;
      REG_CMD:         rd_value = dd.status;
      REG_BM:          rd_value = dd.bm_status;
      REG_CTRL_STATUS: rd_value = ctrl_status_word(dd.cmd_request, dd.hard_reset);
      default:         rd_value = '0;
    endcase
  end

  // Register actions, bus response and drive-side outputs.
  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      bus.ack        <= 1'b0;
      bus.rdata      <= '0;
      dd.hard_reset  <= 1'b0;
      dd.cmd_request <= 1'b0;
      dd.command     <= '0;
      dd.data_input  <= '0;
      dd.bm_request  <= 1'b0;
      dd.bm_control  <= '0;
      pend_cmd       <= '0;
    end else begin
      dd.hard_reset <= n64_hard_reset;
      dd.bm_request <= 1'b0;
      bus.ack       <= 1'b0;
      bus.rdata     <= '0;

      if (dd.cmd_request && dd.cmd_ack) dd.cmd_request <= 1'b0;

      if (stall) pend_cmd <= bus.wdata[7:0];

      if (accept) begin
        bus.ack <= 1'b1;
        if (!bus.write) begin
          bus.rdata <= rd_value;
        end else begin
          case (reg_sel)
            REG_DATA: dd.data_input <= bus.wdata;
            REG_CMD: begin
              if (!locked) begin
                dd.command     <= bus.wdata[7:0];
                dd.cmd_request <= 1'b1;
              end
            end
            REG_BM: begin
              if (!locked) begin
                dd.bm_control <= bus.wdata;
                dd.bm_request <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      if (release_cmd) begin
        bus.ack        <= 1'b1;
        dd.command     <= pend_cmd;
        dd.cmd_request <= 1'b1;
      end

      if (release_drop) bus.ack <= 1'b1;

      // Hard-reset edge wins over any command set in the same cycle.
      if (hr_rise) dd.cmd_request <= 1'b0;
    end
  end

endmodule
